// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: FSM encodings, S-box mode select and ROM geometry.
package aes_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_e;

    localparam logic SBOX_FWD = 1'b0;
    localparam logic SBOX_INV = 1'b1;

    localparam int ROM_AW = 9;
    localparam int ROM_DW = 8;

    // Two bytes are looked up per cycle, so a word needs ceil(lanes/2) issues.
    function automatic int issue_cycles(input int lanes);
        return (lanes + 1) / 2;
    endfunction

endpackage

// File: rtl/sbox_sub_word_engine_if.sv
// Word-in / word-out handshake bundle of the S-box substitution engine.
interface sbox_sub_word_engine_if #(
    parameter int LANES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [8*LANES-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [8*LANES-1:0] out_data;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sbox_rom_2p.sv
// Purpose: 512x8 AES S-box ROM, entries 0..255 forward and 256..511 inverse, two read ports.
// Latency: READ_LAT cycles from address to data (1 = single read register, 2 = extra output register).
// Backpressure: none; addresses are consumed every cycle.
module sbox_rom_2p
    import aes_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROM_AW-1:0] addr_a,
    input  logic [ROM_AW-1:0] addr_b,
    output logic [ROM_DW-1:0] data_a,
    output logic [ROM_DW-1:0] data_b
);

    typedef logic [0:255][7:0] tbl_t;

    localparam tbl_t FWD_TBL = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // The inverse half is derived from the forward half at elaboration so the two can never disagree.
    function automatic tbl_t invert(input tbl_t f);
        tbl_t r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            r[f[i]] = 8'(i);
        end
        return r;
    endfunction

    localparam tbl_t INV_TBL = invert(FWD_TBL);

    function automatic logic [ROM_DW-1:0] lookup(input logic [ROM_AW-1:0] a);
        return (a[ROM_AW-1] == SBOX_INV) ? INV_TBL[a[7:0]] : FWD_TBL[a[7:0]];
    endfunction

    logic [ROM_DW-1:0] rd_a_q;
    logic [ROM_DW-1:0] rd_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= lookup(addr_a);
            rd_b_q <= lookup(addr_b);
        end
    end

    if (READ_LAT == 2) begin : g_outreg
        logic [ROM_DW-1:0] out_a_q;
        logic [ROM_DW-1:0] out_b_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_a_q <= '0;
                out_b_q <= '0;
            end else begin
                out_a_q <= rd_a_q;
                out_b_q <= rd_b_q;
            end
        end

        assign data_a = out_a_q;
        assign data_b = out_b_q;
    end else begin : g_bypass
        assign data_a = rd_a_q;
        assign data_b = rd_b_q;
    end

endmodule

// File: rtl/sbox_sub_word_engine.sv
// Purpose: SubBytes/InvSubBytes on a LANES-byte word, two bytes per cycle through a shared 2-port S-box ROM.
// Latency: out_valid rises ceil(LANES/2)+READ_LAT cycles after the accepting edge; one word in flight at a time.
// Backpressure: out_data is held in DONE until out_ready; in_ready is low from accept until the output handshake.
module sbox_sub_word_engine
    import aes_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int READ_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sbox_sub_word_engine_if.slave  bus
);

    localparam int K  = issue_cycles(LANES);
    localparam int JW = (K > 1) ? $clog2(K) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(K - 1);
    localparam logic [JW-1:0] D_LAST = JW'(READ_LAT - 1);

    state_e state_q, state_d;
    logic [JW-1:0] j_q, j_d;
    logic [8*LANES-1:0] word_q;
    logic [8*LANES-1:0] out_q;
    logic inv_q;
    logic accept;

    logic [READ_LAT-1:0]         tag_vld_q;
    logic [READ_LAT-1:0][JW-1:0] tag_j_q;

    logic [7:0] byte_a, byte_b;
    logic has_b;
    logic [ROM_AW-1:0] addr_a, addr_b;
    logic [ROM_DW-1:0] data_a, data_b;

    assign accept = bus.in_valid && (state_q == IDLE);

    // j counts issues in ISSUE and is reused as the wait counter in DRAIN.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    j_d     = '0;
                end
            end
            ISSUE: begin
                if (j_q == J_LAST) begin
                    state_d = DRAIN;
                    j_d     = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DRAIN: begin
                if (j_q == D_LAST) begin
                    state_d = DONE;
                    j_d     = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_a = '0;
        byte_b = '0;
        has_b  = 1'b0;
        for (int b = 0; b < LANES; b++) begin
            if (j_q == JW'(b / 2)) begin
                if (b % 2 == 0) begin
                    byte_a = word_q[8*b +: 8];
                end else begin
                    byte_b = word_q[8*b +: 8];
                    has_b  = 1'b1;
                end
            end
        end
    end

    // Port B sits at address 0 on the final issue of an odd-width word; its result is never captured.
    assign addr_a = (state_q == ISSUE)          ? {inv_q, byte_a} : '0;
    assign addr_b = (state_q == ISSUE && has_b) ? {inv_q, byte_b} : '0;

    sbox_rom_2p #(
        .READ_LAT (READ_LAT)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (data_a),
        .data_b (data_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            j_q       <= '0;
            word_q    <= '0;
            inv_q     <= SBOX_FWD;
            tag_vld_q <= '0;
            tag_j_q   <= '0;
            out_q     <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            if (accept) begin
                word_q <= bus.in_data;
                inv_q  <= bus.in_inv;
            end
            for (int i = READ_LAT - 1; i > 0; i--) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_j_q[i]   <= tag_j_q[i-1];
            end
            tag_vld_q[0] <= (state_q == ISSUE);
            tag_j_q[0]   <= j_q;
            // The oldest tag lines up with the ROM data currently on its outputs.
            for (int b = 0; b < LANES; b++) begin
                if (tag_vld_q[READ_LAT-1] && tag_j_q[READ_LAT-1] == JW'(b / 2)) begin
                    out_q[8*b +: 8] <= (b % 2 == 0) ? data_a : data_b;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_sbox_sub_word_engine.sv
// Self-checking bench: seven engine configurations driven through their interfaces, checked against constants and a GF(2^8) S-box model.
module tb_sbox_sub_word_engine;

    localparam int NCFG = 7;

    function automatic int cfg_lanes(input int g);
        case (g)
            0: return 4;
            1: return 4;
            2: return 3;
            3: return 16;
            4: return 1;
            5: return 1;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_rlat(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 1;
            3: return 2;
            4: return 1;
            5: return 2;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         in_valid  [NCFG];
    logic         in_inv    [NCFG];
    logic [127:0] in_data   [NCFG];
    logic         out_ready [NCFG];
    logic         in_ready  [NCFG];
    logic         out_valid [NCFG];
    logic [127:0] out_data  [NCFG];

    int checks = 0;
    int failures = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : gen_dut
        localparam int L = cfg_lanes(g);
        localparam int R = cfg_rlat(g);

        sbox_sub_word_engine_if #(.LANES(L)) ifc ();

        assign ifc.in_valid  = in_valid[g];
        assign ifc.in_inv    = in_inv[g];
        assign ifc.in_data   = in_data[g][8*L-1:0];
        assign ifc.out_ready = out_ready[g];
        assign in_ready[g]   = ifc.in_ready;
        assign out_valid[g]  = ifc.out_valid;
        assign out_data[g]   = 128'(ifc.out_data);

        sbox_sub_word_engine #(.LANES(L), .READ_LAT(R)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] iv, s;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (x != 0 && gmul(8'(x), 8'(b)) == 8'h01) iv = 8'(b);
            end
            s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_word(input int l, input logic inv, input logic [127:0] d);
        logic [127:0] r = '0;
        for (int i = 0; i < l; i++) begin
            r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
        end
        return r;
    endfunction

    // Presents one word, scrambles the inputs after acceptance, and waits for out_valid.
    task automatic do_word(input int g, input logic inv, input logic [127:0] d,
                           output int lat, output int rdy_seen, output logic [127:0] q);
        int n;
        out_ready[g] = 1'b0;
        in_valid[g]  = 1'b1;
        in_inv[g]    = inv;
        in_data[g]   = d;
        n = 0;
        while (!in_ready[g] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        in_inv[g]   = ~inv;
        in_data[g]  = ~d;
        lat = 0;
        rdy_seen = 0;
        while (!out_valid[g] && lat < 100) begin
            if (in_ready[g]) rdy_seen++;
            @(posedge clk); #1;
            lat++;
        end
        q = out_data[g];
    endtask

    task automatic release_word(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk); #1;
        out_ready[g] = 1'b0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < NCFG; g++) begin
            checks++;
            if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || out_data[g] !== 128'h0) begin
                failures++;
                $display("FAIL reset_state cfg%0d: in_ready=%b out_valid=%b out_data=%h, want 1 0 0", g, in_ready[g], out_valid[g], out_data[g]);
            end
        end
    endtask

    task automatic test_fwd_l4r1();
        int lat, rs;
        logic [127:0] q;
        do_word(0, 1'b0, 128'h00112233, lat, rs, q);
        checks++;
        if (q !== 128'h638293C3) begin
            failures++;
            $display("FAIL fwd_l4r1_data: got %h want 638293c3", q);
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL fwd_l4r1_latency: got %0d want 3", lat);
        end
        checks++;
        if (rs !== 0) begin
            failures++;
            $display("FAIL fwd_l4r1_busy_ready: in_ready high on %0d busy cycles, want 0", rs);
        end
        release_word(0);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL fwd_l4r1_release: in_ready=%b out_valid=%b, want 1 0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_inv_l4r2();
        int lat, rs;
        logic [127:0] q;
        do_word(1, 1'b1, 128'h638293C3, lat, rs, q);
        checks++;
        if (q !== 128'h00112233) begin
            failures++;
            $display("FAIL inv_l4r2_data: got %h want 00112233", q);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL inv_l4r2_latency: got %0d want 4", lat);
        end
        release_word(1);
        do_word(1, 1'b0, 128'h53535353, lat, rs, q);
        checks++;
        if (q !== 128'hEDEDEDED) begin
            failures++;
            $display("FAIL fwd_l4r2_data: got %h want edededed", q);
        end
        release_word(1);
    endtask

    task automatic test_odd_lanes();
        int lat;
        in_valid[2] = 1'b1;
        in_inv[2]   = 1'b0;
        in_data[2]  = 128'h005300;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        in_data[2]  = '0;
        checks++;
        if (gen_dut[2].u_dut.addr_b !== 9'h053) begin
            failures++;
            $display("FAIL odd_first_addr_b: got %h want 053", gen_dut[2].u_dut.addr_b);
        end
        @(posedge clk); #1;
        checks++;
        if (gen_dut[2].u_dut.addr_b !== 9'h000) begin
            failures++;
            $display("FAIL odd_last_addr_b: got %h want 000", gen_dut[2].u_dut.addr_b);
        end
        lat = 1;
        while (!out_valid[2] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 3 || out_data[2] !== 128'h63ED63) begin
            failures++;
            $display("FAIL odd_l3r1: latency=%0d data=%h, want 3 63ed63", lat, out_data[2]);
        end
        release_word(2);
    endtask

    task automatic test_backpressure();
        int lat, rs;
        logic [127:0] q;
        do_word(0, 1'b0, 128'hDEADBEEF, lat, rs, q);
        checks++;
        if (q !== 128'h1D95AEDF || lat !== 3) begin
            failures++;
            $display("FAIL bp_first: data=%h latency=%0d, want 1d95aedf 3", q, lat);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = (i % 2 == 0);
            in_data[0]  = 128'h11111111;
            @(posedge clk); #1;
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 128'h1D95AEDF || in_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b out_data=%h in_ready=%b, want 1 1d95aedf 0", i, out_valid[0], out_data[0], in_ready[0]);
            end
        end
        in_valid[0] = 1'b0;
        release_word(0);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic prev_v;
        int nvalid;
        prev_v = 1'b0;
        nvalid = 0;
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_inv[1]    = 1'b0;
        in_data[1]   = 128'h00000000;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (prev_v) begin
                checks++;
                if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_after_handshake cycle %0d: out_valid=%b in_ready=%b, want 0 1", i, out_valid[1], in_ready[1]);
                end
            end
            if (out_valid[1]) begin
                nvalid++;
                checks++;
                if (out_data[1] !== 128'h63636363) begin
                    failures++;
                    $display("FAIL b2b_data cycle %0d: got %h want 63636363", i, out_data[1]);
                end
            end
            prev_v = out_valid[1];
        end
        in_valid[1] = 1'b0;
        checks++;
        if (nvalid < 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d words in 30 cycles, want at least 3", nvalid);
        end
        for (int i = 0; i < 12 && !in_ready[1]; i++) begin
            @(posedge clk); #1;
        end
        out_ready[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, rs, stray;
        logic [127:0] q;
        do_word(3, 1'b0, {16{8'h53}}, lat, rs, q);
        checks++;
        if (q !== {16{8'hED}} || lat !== 10) begin
            failures++;
            $display("FAIL l16r2_word: data=%h latency=%0d, want all ed 10", q, lat);
        end
        release_word(3);
        in_valid[3] = 1'b1;
        in_inv[3]   = 1'b0;
        in_data[3]  = {16{8'h11}};
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[3] !== 1'b0 || out_data[3] !== 128'h0 || in_ready[3] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_async: out_valid=%b out_data=%h in_ready=%b, want 0 0 1", out_valid[3], out_data[3], in_ready[3]);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid[3] || out_data[3] != 128'h0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_partial: %0d cycles with output activity, want 0", stray);
        end
        do_word(3, 1'b0, 128'h0, lat, rs, q);
        checks++;
        if (q !== {16{8'h63}} || lat !== 10) begin
            failures++;
            $display("FAIL reset_mid_next_word: data=%h latency=%0d, want all 63 10", q, lat);
        end
        release_word(3);
    endtask

    task automatic test_sweep();
        int sweep_cfg [6] = '{0, 1, 3, 4, 5, 6};
        int g, l, lat, rs, stall;
        logic inv;
        logic [127:0] d, mask, q, exp;
        for (int s = 0; s < 6; s++) begin
            g = sweep_cfg[s];
            l = cfg_lanes(g);
            mask = '0;
            for (int i = 0; i < l; i++) mask[8*i +: 8] = 8'hff;
            for (int w = 0; w < 6; w++) begin
                d   = {$urandom(), $urandom(), $urandom(), $urandom()} & mask;
                inv = 1'($urandom_range(0, 1));
                do_word(g, inv, d, lat, rs, q);
                stall = $urandom_range(0, 4);
                repeat (stall) begin
                    @(posedge clk); #1;
                end
                exp = ref_word(l, inv, d);
                checks++;
                if (out_valid[g] !== 1'b1 || out_data[g] !== exp) begin
                    failures++;
                    $display("FAIL sweep cfg%0d word%0d inv=%b in=%h: out_valid=%b got %h want %h", g, w, inv, d, out_valid[g], out_data[g], exp);
                end
                checks++;
                if (lat !== (l + 1) / 2 + cfg_rlat(g)) begin
                    failures++;
                    $display("FAIL sweep_latency cfg%0d word%0d: got %0d want %0d", g, w, lat, (l + 1) / 2 + cfg_rlat(g));
                end
                release_word(g);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int g = 0; g < NCFG; g++) begin
            in_valid[g]  = 1'b0;
            in_inv[g]    = 1'b0;
            in_data[g]   = '0;
            out_ready[g] = 1'b0;
        end
        build_model();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fwd_l4r1();
        test_inv_l4r2();
        test_odd_lanes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
